// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
// Memory-mapped 8N1 UART transmitter with a small byte FIFO.
//
// Register map (offset selected by addr[4:3]):
//   0 TXDATA : write byte 0 pushes wdata[7:0] into the TX FIFO; reads as 0
//   1 STATUS : bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky),
//              bits[15:8] FIFO count; writing bit3=1 clears overflow
//   2 CTRL   : bit0 enable (starts/stops new frames)
//   3 unmapped: reads 0, writes ignored
//
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-low reset
//   valid  - request valid (always accepted; ready is high outside reset)
//   ready  - request accept
//   addr   - byte address, only addr[4:3] decoded
//   wen    - 1 = write, 0 = read
//   wdata  - write data
//   wmask  - byte write enables, only wmask[0] matters
//   rvalid - one-cycle response pulse the cycle after each request
//   rdata  - read data, valid while rvalid=1 (0 for writes)
//   tx     - serial output, idle high, LSB first

module mmio_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8,
  parameter int XLEN         = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  output logic            ready,
  input  logic [XLEN-1:0] addr,
  input  logic            wen,
  input  logic [63:0]     wdata,
  input  logic [7:0]      wmask,
  output logic            rvalid,
  output logic [63:0]     rdata,
  output logic            tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]      BIT_RELOAD = 16'(CLKS_PER_BIT - 1);

  localparam logic [1:0] SEL_TXDATA = 2'd0;
  localparam logic [1:0] SEL_STATUS = 2'd1;
  localparam logic [1:0] SEL_CTRL   = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state;
  state_t state_next;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  logic             overflow;
  logic             enable;

  logic [15:0]      bit_cnt;
  logic [15:0]      bit_cnt_next;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_next;
  logic [7:0]       shift_reg;
  logic [7:0]       shift_next;
  logic             tx_next;
  logic             pop;

  logic [1:0]       reg_sel;
  logic             wr_byte0;
  logic             txdata_wr;
  logic             push;
  logic             overflow_set;
  logic             overflow_clr;
  logic             ctrl_wr;
  logic [63:0]      rdata_next;

  // Only these address/data bits carry meaning; the rest are accepted and ignored.
  logic unused_inputs;
  assign unused_inputs = ^{addr[XLEN-1:5], addr[2:0], wdata[63:8], wmask[7:1]};

  // The bus is never back-pressured; ready simply follows reset release.
  assign ready = rst;

  assign reg_sel    = addr[4:3];
  assign fifo_full  = (fifo_count == DEPTH_C);
  assign fifo_empty = (fifo_count == '0);

  // Fullness uses the count at the start of the cycle, so a same-cycle pop
  // never frees a slot for a push arriving in that cycle.
  assign wr_byte0     = valid && wen && wmask[0];
  assign txdata_wr    = wr_byte0 && (reg_sel == SEL_TXDATA);
  assign push         = txdata_wr && !fifo_full;
  assign overflow_set = txdata_wr && fifo_full;
  assign overflow_clr = wr_byte0 && (reg_sel == SEL_STATUS) && wdata[3];
  assign ctrl_wr      = wr_byte0 && (reg_sel == SEL_CTRL);

  // FIFO storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= wdata[7:0];
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sticky overflow flag and the enable bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      enable   <= 1'b1;
    end else begin
      if (overflow_set) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
      if (ctrl_wr) begin
        enable <= wdata[0];
      end
    end
  end

  // Read mux, evaluated in the accept cycle so STATUS reflects that cycle.
  always_comb begin
    rdata_next = '0;
    if (!wen) begin
      case (reg_sel)
        SEL_STATUS: begin
          rdata_next[0]    = fifo_full;
          rdata_next[1]    = fifo_empty;
          rdata_next[2]    = (state != IDLE);
          rdata_next[3]    = overflow;
          rdata_next[15:8] = 8'(fifo_count);
        end
        SEL_CTRL: begin
          rdata_next[0] = enable;
        end
        default: begin
          rdata_next = '0;
        end
      endcase
    end
  end

  // Every accepted request gets exactly one response pulse the next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= valid;
      if (valid) begin
        rdata <= rdata_next;
      end
    end
  end

  // Transmitter state register; tx is registered alongside it so the line
  // is glitch-free and is forced high the moment reset asserts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      bit_idx   <= bit_idx_next;
      shift_reg <= shift_next;
      tx        <= tx_next;
    end
  end

  // Next-state logic. bit_cnt counts down from CLKS_PER_BIT-1 and is
  // reloaded at each bit boundary; the line level for the next cycle is
  // derived from the next state so tx changes on the same edge as state.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift_reg;
    pop          = 1'b0;

    case (state)
      IDLE: begin
        if (enable && !fifo_empty) begin
          pop          = 1'b1;
          shift_next   = fifo_mem[rd_ptr];
          bit_cnt_next = BIT_RELOAD;
          state_next   = START;
        end
      end
      START: begin
        if (bit_cnt == '0) begin
          bit_cnt_next = BIT_RELOAD;
          bit_idx_next = '0;
          state_next   = DATA;
        end else begin
          bit_cnt_next = bit_cnt - 16'd1;
        end
      end
      DATA: begin
        if (bit_cnt == '0) begin
          bit_cnt_next = BIT_RELOAD;
          shift_next   = {1'b0, shift_reg[7:1]};
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          bit_cnt_next = bit_cnt - 16'd1;
        end
      end
      STOP: begin
        if (bit_cnt == '0) begin
          state_next = IDLE;
        end else begin
          bit_cnt_next = bit_cnt - 16'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx
// Self-checking bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A reference model steps once per clock from the request inputs and
// queues the expected bus responses and serial frames; two monitors
// compare what the DUT actually produces against those queues.

module tb_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        ready;
  logic [63:0] addr;
  logic        wen;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic        rvalid;
  logic [63:0] rdata;
  logic        tx;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic        last_rvalid;
  logic [63:0] last_rdata;

  typedef struct {
    logic        is_read;
    logic [63:0] data;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } frm_t;

  rsp_t       exp_rsp[$];
  frm_t       exp_tx[$];
  logic [7:0] mq[$];
  logic       m_ovf;
  logic       m_en;
  int         m_left;
  int         starts[$];

  mmio_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .XLEN        (64)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .ready (ready),
    .addr  (addr),
    .wen   (wen),
    .wdata (wdata),
    .wmask (wmask),
    .rvalid(rvalid),
    .rdata (rdata),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  // Drives one request for one cycle; upper/lower address bits are random
  // so only the offset field can influence the result.
  task automatic applyStimulus(input logic w, input logic [1:0] off,
                               input logic [63:0] d, input logic [7:0] m);
    logic [63:0] a;
    a      = {$urandom, $urandom};
    a[4:3] = off;
    valid  = 1'b1;
    wen    = w;
    addr   = a;
    wdata  = d;
    wmask  = m;
    @(posedge clk);
    #1;
    valid       = 1'b0;
    wen         = 1'b0;
    wmask       = 8'h00;
    last_rvalid = rvalid;
    last_rdata  = rdata;
  endtask

  task automatic readCheck(input string name, input logic [1:0] off, input logic [63:0] req);
    applyStimulus(1'b0, off, 64'h0, 8'h00);
    checkOutput({name, "_rvalid"}, last_rvalid, 1);
    checkOutput(name, last_rdata, req);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: one step per clock, using the state at the start of
  // the cycle. A frame occupies the line for FRAME cycles starting the
  // cycle after the byte leaves the FIFO.
  always @(posedge clk) begin : model
    int          cnt;
    logic        busy_s;
    logic        pop_s;
    logic [63:0] st;
    rsp_t        r;
    frm_t        f;
    if (!rst) begin
      mq.delete();
      exp_tx.delete();
      exp_rsp.delete();
      m_ovf  = 1'b0;
      m_en   = 1'b1;
      m_left = 0;
    end else begin
      cnt    = mq.size();
      busy_s = (m_left > 0);
      pop_s  = !busy_s && m_en && (cnt > 0);
      if (busy_s) begin
        m_left--;
      end else if (pop_s) begin
        f.data = mq.pop_front();
        f.cyc  = cyc + 1;
        exp_tx.push_back(f);
        m_left = FRAME;
      end
      if (valid) begin
        st        = 64'h0;
        st[0]     = (cnt == DEPTH);
        st[1]     = (cnt == 0);
        st[2]     = busy_s;
        st[3]     = m_ovf;
        st[15:8]  = 8'(cnt);
        r.is_read = !wen;
        r.cyc     = cyc + 1;
        case (addr[4:3])
          2'd1:    r.data = st;
          2'd2:    r.data = {63'h0, m_en};
          default: r.data = 64'h0;
        endcase
        exp_rsp.push_back(r);
        if (wen && wmask[0]) begin
          case (addr[4:3])
            2'd0: begin
              if (cnt == DEPTH) m_ovf = 1'b1;
              else mq.push_back(wdata[7:0]);
            end
            2'd1: if (wdata[3]) m_ovf = 1'b0;
            2'd2: m_en = wdata[0];
            default: ;
          endcase
        end
      end
    end
    cyc++;
  end

  // Response monitor: each expected response must appear exactly in its cycle.
  always @(negedge clk) begin : rsp_monitor
    rsp_t r;
    if (rst) begin
      if (exp_rsp.size() != 0 && exp_rsp[0].cyc == cyc) begin
        r = exp_rsp.pop_front();
        checkOutput("rvalid_pulse", rvalid, 1);
        if (r.is_read) checkOutput("rdata", rdata, r.data);
      end else begin
        checkOutput("rvalid_idle", rvalid, 0);
      end
    end
  end

  // Serial monitor: decodes frames from the line by sampling mid-bit and
  // matches them, with their start cycle, against the expected frames.
  int         mon_pos = -1;
  int         mon_start;
  logic [9:0] mon_bits;

  always @(negedge clk) begin : tx_monitor
    frm_t f;
    if (!rst) begin
      mon_pos = -1;
      checkOutput("reset_tx", tx, 1);
      checkOutput("reset_ready", ready, 0);
      checkOutput("reset_rvalid", rvalid, 0);
      checkOutput("reset_rdata", rdata, 0);
    end else begin
      if (mon_pos < 0 && tx == 1'b0) begin
        mon_pos   = 0;
        mon_start = cyc;
        starts.push_back(cyc);
      end
      if (mon_pos >= 0) begin
        if (mon_pos % CPB == CPB / 2) mon_bits[mon_pos / CPB] = tx;
        if (mon_pos == FRAME - 1) begin
          checkOutput("frame_expected", exp_tx.size() != 0, 1);
          checkOutput("start_bit", mon_bits[0], 0);
          checkOutput("stop_bit", mon_bits[9], 1);
          if (exp_tx.size() != 0) begin
            f = exp_tx.pop_front();
            checkOutput("tx_byte", mon_bits[8:1], f.data);
            checkOutput("frame_start_cycle", mon_start, f.cyc);
          end
          mon_pos = -1;
        end else begin
          mon_pos++;
        end
      end
    end
  end

  initial begin : watchdog
    repeat (40000) @(posedge clk);
    failures++;
    $display("[TB] FAIL watchdog actual=timeout required=finish cycle=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [1:0]  off;
    logic [63:0] d;
    logic [7:0]  m;
    int          waited;

    rst   = 1'b1;
    valid = 1'b0;
    wen   = 1'b0;
    addr  = '0;
    wdata = '0;
    wmask = '0;
    #1 rst = 1'b0;
    #1;
    checkOutput("init_ready", ready, 0);
    checkOutput("init_rvalid", rvalid, 0);
    checkOutput("init_rdata", rdata, 0);
    checkOutput("init_tx", tx, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("ready_after_reset", ready, 1);

    // Single 0x55 frame; count=1 and idle the cycle after the write, busy after that.
    applyStimulus(1'b1, 2'd0, 64'h55, 8'h01);
    checkOutput("txdata_wr_rvalid", last_rvalid, 1);
    readCheck("status_n1", 2'd1, 64'h0100);
    readCheck("status_n2", 2'd1, 64'h0006);
    checkOutput("tx_start_low", tx, 0);
    idleCycles(40);
    readCheck("status_after_frame", 2'd1, 64'h0002);

    // Masked-off TXDATA write and an unmapped read.
    applyStimulus(1'b1, 2'd0, 64'h77, 8'h00);
    readCheck("status_mask0", 2'd1, 64'h0002);
    readCheck("unmapped_read", 2'd3, 64'h0);

    // Overflow with transmission disabled: full | overflow | count 4.
    applyStimulus(1'b1, 2'd2, 64'h0, 8'h01);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'd0, 64'($urandom_range(0, 255)), 8'h01);
    readCheck("status_overflow", 2'd1, 64'h0409);
    applyStimulus(1'b1, 2'd1, 64'h8, 8'h01);
    readCheck("status_ovf_cleared", 2'd1, 64'h0401);

    // Back-to-back requests on consecutive cycles; enabling drains the FIFO.
    applyStimulus(1'b0, 2'd1, 64'h0, 8'h00);
    checkOutput("b2b_rvalid0", last_rvalid, 1);
    checkOutput("b2b_status", last_rdata, 64'h0401);
    applyStimulus(1'b1, 2'd2, 64'h1, 8'h01);
    checkOutput("b2b_rvalid1", last_rvalid, 1);
    applyStimulus(1'b0, 2'd2, 64'h0, 8'h00);
    checkOutput("b2b_rvalid2", last_rvalid, 1);
    checkOutput("b2b_ctrl", last_rdata, 64'h1);
    idleCycles(4 * (FRAME + 1) + 20);

    // Disabled with two bytes queued, then minimum frame spacing.
    applyStimulus(1'b1, 2'd2, 64'h0, 8'h01);
    readCheck("ctrl_off", 2'd2, 64'h0);
    applyStimulus(1'b1, 2'd0, 64'h96, 8'h01);
    applyStimulus(1'b1, 2'd0, 64'h0F, 8'h01);
    idleCycles(30);
    checkOutput("tx_idle_disabled", tx, 1);
    readCheck("status_two_queued", 2'd1, 64'h0200);
    starts.delete();
    applyStimulus(1'b1, 2'd2, 64'h1, 8'h01);
    idleCycles(2 * (FRAME + 1) + 10);
    checkOutput("frame_count", starts.size(), 2);
    if (starts.size() == 2) checkOutput("frame_gap", starts[1] - starts[0], FRAME + 1);

    // Reset during data bit 3 of 0xA5 (a 0 bit) with a second byte queued.
    applyStimulus(1'b1, 2'd0, 64'hA5, 8'h01);
    applyStimulus(1'b1, 2'd0, 64'h3C, 8'h01);
    repeat (17) @(posedge clk);
    #1;
    checkOutput("tx_bit3_low", tx, 0);
    rst = 1'b0;
    #1;
    checkOutput("tx_async_reset", tx, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    readCheck("status_after_reset", 2'd1, 64'h0002);
    idleCycles(FRAME + 20);
    checkOutput("no_residual_frame", tx, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 40) begin
        idleCycles(1);
      end else begin
        off = 2'($urandom_range(0, 3));
        d   = {$urandom, $urandom};
        if (off == 2'd2) d[0] = ($urandom_range(0, 3) != 0);
        m = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) m[0] = 1'b1;
        applyStimulus(1'($urandom_range(0, 1)), off, d, m);
      end
    end

    // Drain everything still queued, bounded by the worst-case backlog.
    applyStimulus(1'b1, 2'd2, 64'h1, 8'h01);
    waited = 0;
    while ((mq.size() != 0 || m_left != 0 || exp_tx.size() != 0) &&
           waited < (DEPTH + 2) * (FRAME + 1) + 20) begin
      idleCycles(1);
      waited++;
    end
    checkOutput("drain_frames_left", exp_tx.size(), 0);
    applyStimulus(1'b1, 2'd1, 64'h8, 8'h01);
    readCheck("final_status", 2'd1, 64'h0002);
    idleCycles(3);
    checkOutput("responses_left", exp_rsp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
